alu_mdu_dec: RTL and testbench

//  Next-generation ALU decoder for the MIPS core, in the execute stage. Maps aluop/funct to a 4-bit

---
 rtl/alu_pkg.sv | 53 +++++
 rtl/mdu_iter_core.sv | 57 +++++
 rtl/alu_mdu_dec.sv | 129 ++++++++++++
 tb/tb_alu_mdu_dec.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: shared encodings for the execute-stage ALU decoder and the multiply/divide unit.
package alu_pkg;
    localparam logic [3:0] ALUCTRL_AND  = 4'b0000;
    localparam logic [3:0] ALUCTRL_OR   = 4'b0001;
    localparam logic [3:0] ALUCTRL_ADD  = 4'b0010;
    localparam logic [3:0] ALUCTRL_XOR  = 4'b0011;
    localparam logic [3:0] ALUCTRL_NOR  = 4'b0100;
    localparam logic [3:0] ALUCTRL_SUB  = 4'b0110;
    localparam logic [3:0] ALUCTRL_SLT  = 4'b0111;
    localparam logic [3:0] ALUCTRL_SLL  = 4'b1000;
    localparam logic [3:0] ALUCTRL_SRL  = 4'b1001;
    localparam logic [3:0] ALUCTRL_SRA  = 4'b1010;
    localparam logic [3:0] ALUCTRL_SLTU = 4'b1111;

    localparam logic [5:0] FUNCT_SLL   = 6'b000000;
    localparam logic [5:0] FUNCT_SRL   = 6'b000010;
    localparam logic [5:0] FUNCT_SRA   = 6'b000011;
    localparam logic [5:0] FUNCT_MFHI  = 6'b010000;
    localparam logic [5:0] FUNCT_MTHI  = 6'b010001;
    localparam logic [5:0] FUNCT_MFLO  = 6'b010010;
    localparam logic [5:0] FUNCT_MTLO  = 6'b010011;
    localparam logic [5:0] FUNCT_MULT  = 6'b011000;
    localparam logic [5:0] FUNCT_MULTU = 6'b011001;
    localparam logic [5:0] FUNCT_DIV   = 6'b011010;
    localparam logic [5:0] FUNCT_DIVU  = 6'b011011;
    localparam logic [5:0] FUNCT_ADD   = 6'b100000;
    localparam logic [5:0] FUNCT_ADDU  = 6'b100001;
    localparam logic [5:0] FUNCT_SUB   = 6'b100010;
    localparam logic [5:0] FUNCT_SUBU  = 6'b100011;
    localparam logic [5:0] FUNCT_AND   = 6'b100100;
    localparam logic [5:0] FUNCT_OR    = 6'b100101;
    localparam logic [5:0] FUNCT_XOR   = 6'b100110;
    localparam logic [5:0] FUNCT_NOR   = 6'b100111;
    localparam logic [5:0] FUNCT_SLT   = 6'b101010;
    localparam logic [5:0] FUNCT_SLTU  = 6'b101011;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;
    localparam logic [1:0] ALUOP_OR    = 2'b11;

    localparam logic [1:0] SEL_ALU = 2'b00;
    localparam logic [1:0] SEL_HI  = 2'b01;
    localparam logic [1:0] SEL_LO  = 2'b10;

    // Encoded to match funct[1:0] of the four MDU instructions.
    typedef enum logic [1:0] {MDU_MULT = 2'b00, MDU_MULTU = 2'b01, MDU_DIV = 2'b10, MDU_DIVU = 2'b11} mdu_op_e;
    typedef enum logic [1:0] {S_IDLE = 2'b00, S_RUN = 2'b01, S_FIX = 2'b10} mdu_state_e;

    function automatic logic is_div_op(mdu_op_e op);
        return op == MDU_DIV || op == MDU_DIVU;
    endfunction
endpackage

// File: rtl/mdu_iter_core.sv
// mdu_iter_core: WIDTH-step shift-add multiplier / restoring divider on unsigned magnitudes.
module mdu_iter_core #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_i,
    input  logic             step_i,
    input  logic             div_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o,
    output logic             done_o
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d, m_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH:0]   sum, shifted;
    logic [WIDTH+1:0] diff;
    logic             ge;

    // Multiply: hi accumulates, lo holds the multiplier and collects product bits.
    // Divide: hi is the partial remainder, lo shifts dividend out and quotient in.
    always_comb begin
        sum     = {1'b0, hi_q} + (lo_q[0] ? {1'b0, m_q} : '0);
        shifted = {hi_q, lo_q[WIDTH-1]};
        diff    = {1'b0, shifted} - {2'b00, m_q};
        ge      = ~diff[WIDTH+1];
        hi_d    = div_i ? (ge ? diff[WIDTH-1:0] : shifted[WIDTH-1:0]) : sum[WIDTH:1];
        lo_d    = div_i ? {lo_q[WIDTH-2:0], ge} : {sum[0], lo_q[WIDTH-1:1]};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
            hi_q  <= '0;
            lo_q  <= '0;
            m_q   <= '0;
        end else if (load_i) begin
            cnt_q <= '0;
            hi_q  <= '0;
            lo_q  <= a_i;
            m_q   <= b_i;
        end else if (step_i) begin
            cnt_q <= cnt_q + 1'b1;
            hi_q  <= hi_d;
            lo_q  <= lo_d;
        end
    end

    assign hi_o   = hi_q;
    assign lo_o   = lo_q;
    assign done_o = step_i & (cnt_q == LAST);
endmodule

// File: rtl/alu_mdu_dec.sv
// alu_mdu_dec: execute-stage ALU decoder with an iterative multiply/divide unit owning HI/LO.
module alu_mdu_dec
    import alu_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int ALUCTRL_W = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 en,
    input  logic [1:0]           aluop,
    input  logic [5:0]           funct,
    input  logic [WIDTH-1:0]     srca,
    input  logic [WIDTH-1:0]     srcb,
    output logic [ALUCTRL_W-1:0] alucontrol,
    output logic                 illegal,
    output logic                 stall,
    output logic                 mdu_busy,
    output logic [1:0]           mdu_sel,
    output logic [WIDTH-1:0]     hi,
    output logic [WIDTH-1:0]     lo
);
    mdu_state_e         state_q, state_d;
    mdu_op_e            op_q;
    logic               sa_q, sb_q, bz_q;
    logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
    logic [WIDTH-1:0]   core_hi, core_lo, a_mag, b_mag, quo, rem;
    logic [2*WIDTH-1:0] prod;
    logic [3:0]         rctrl;
    logic               r_type, is_hilo, is_mdu, known, issue, signed_op, done, mthi_we, mtlo_we;

    assign r_type  = aluop == ALUOP_RTYPE;
    assign is_hilo = funct[5:2] == 4'b0100;
    assign is_mdu  = funct[5:2] == 4'b0110;

    always_comb begin
        rctrl = ALUCTRL_ADD;
        known = 1'b1;
        case (funct)
            FUNCT_ADD, FUNCT_ADDU: rctrl = ALUCTRL_ADD;
            FUNCT_SUB, FUNCT_SUBU: rctrl = ALUCTRL_SUB;
            FUNCT_AND:             rctrl = ALUCTRL_AND;
            FUNCT_OR:              rctrl = ALUCTRL_OR;
            FUNCT_XOR:             rctrl = ALUCTRL_XOR;
            FUNCT_NOR:             rctrl = ALUCTRL_NOR;
            FUNCT_SLT:             rctrl = ALUCTRL_SLT;
            FUNCT_SLTU:            rctrl = ALUCTRL_SLTU;
            FUNCT_SLL:             rctrl = ALUCTRL_SLL;
            FUNCT_SRL:             rctrl = ALUCTRL_SRL;
            FUNCT_SRA:             rctrl = ALUCTRL_SRA;
            default:               known = is_hilo | is_mdu;
        endcase
    end

    assign alucontrol = ALUCTRL_W'(aluop == ALUOP_ADD ? ALUCTRL_ADD :
                                   aluop == ALUOP_SUB ? ALUCTRL_SUB :
                                   aluop == ALUOP_OR  ? ALUCTRL_OR  : rctrl);
    assign illegal    = r_type & ~known;
    assign mdu_sel    = ~r_type ? SEL_ALU : funct == FUNCT_MFHI ? SEL_HI :
                        funct == FUNCT_MFLO ? SEL_LO : SEL_ALU;

    assign mdu_busy  = state_q != S_IDLE;
    assign stall     = en & mdu_busy & r_type & (is_hilo | is_mdu);
    assign issue     = en & r_type & is_mdu & ~stall;
    assign mthi_we   = en & r_type & (funct == FUNCT_MTHI) & ~stall;
    assign mtlo_we   = en & r_type & (funct == FUNCT_MTLO) & ~stall;
    assign signed_op = ~funct[0];
    assign a_mag     = (signed_op & srca[WIDTH-1]) ? -srca : srca;
    assign b_mag     = (signed_op & srcb[WIDTH-1]) ? -srcb : srcb;

    mdu_iter_core #(.WIDTH(WIDTH)) u_core (
        .clk    (clk),
        .reset  (reset),
        .load_i (issue),
        .step_i (state_q == S_RUN),
        .div_i  (is_div_op(op_q)),
        .a_i    (a_mag),
        .b_i    (b_mag),
        .hi_o   (core_hi),
        .lo_o   (core_lo),
        .done_o (done)
    );

    // Sign correction: the core only ever sees magnitudes; divide-by-zero forces an all-ones quotient.
    assign prod = (sa_q ^ sb_q) ? -{core_hi, core_lo} : {core_hi, core_lo};
    assign quo  = bz_q ? '1 : (sa_q ^ sb_q) ? -core_lo : core_lo;
    assign rem  = sa_q ? -core_hi : core_hi;

    always_comb begin
        state_d = state_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        case (state_q)
            S_IDLE: state_d = issue ? S_RUN : S_IDLE;
            S_RUN:  state_d = done ? S_FIX : S_RUN;
            default: begin
                state_d      = S_IDLE;
                {hi_d, lo_d} = is_div_op(op_q) ? {rem, quo} : prod;
            end
        endcase
        if (mthi_we) hi_d = srca;
        if (mtlo_we) lo_d = srca;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            op_q    <= MDU_MULT;
            sa_q    <= 1'b0;
            sb_q    <= 1'b0;
            bz_q    <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            if (issue) begin
                op_q <= mdu_op_e'(funct[1:0]);
                sa_q <= signed_op & srca[WIDTH-1];
                sb_q <= signed_op & srcb[WIDTH-1];
                bz_q <= srcb == '0;
            end
        end
    end

    assign hi = hi_q;
    assign lo = lo_q;
endmodule

// File: tb/tb_alu_mdu_dec.sv
// tb_alu_mdu_dec: randomized and directed checks of decode, MDU results/timing, stalls and reset.
module tb_alu_mdu_dec;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset, en;
    logic [1:0]   aluop;
    logic [5:0]   funct;
    logic [W-1:0] srca, srcb;
    logic [3:0]   alucontrol;
    logic         illegal, stall, mdu_busy;
    logic [1:0]   mdu_sel;
    logic [W-1:0] hi, lo;

    int checks = 0;
    int errors = 0;
    logic [W-1:0] exp_hi, exp_lo;

    alu_mdu_dec #(.WIDTH(W), .ALUCTRL_W(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .en         (en),
        .aluop      (aluop),
        .funct      (funct),
        .srca       (srca),
        .srcb       (srcb),
        .alucontrol (alucontrol),
        .illegal    (illegal),
        .stall      (stall),
        .mdu_busy   (mdu_busy),
        .mdu_sel    (mdu_sel),
        .hi         (hi),
        .lo         (lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    // {illegal, mdu_sel, alucontrol} straight from the decode table
    function automatic logic [6:0] dec_ref(input logic [1:0] op, input logic [5:0] f);
        logic [3:0] c;
        logic [1:0] s;
        logic       ill;
        c = 4'b0010;
        s = 2'b00;
        ill = 1'b0;
        if (op == 2'b01) c = 4'b0110;
        else if (op == 2'b11) c = 4'b0001;
        else if (op == 2'b10) begin
            case (f)
                6'b100000, 6'b100001: c = 4'b0010;
                6'b100010, 6'b100011: c = 4'b0110;
                6'b100100: c = 4'b0000;
                6'b100101: c = 4'b0001;
                6'b100110: c = 4'b0011;
                6'b100111: c = 4'b0100;
                6'b101010: c = 4'b0111;
                6'b101011: c = 4'b1111;
                6'b000000: c = 4'b1000;
                6'b000010: c = 4'b1001;
                6'b000011: c = 4'b1010;
                default:   ill = !(f[5:2] == 4'b0100 || f[5:2] == 4'b0110);
            endcase
            s = (f == 6'b010000) ? 2'b01 : (f == 6'b010010) ? 2'b10 : 2'b00;
        end
        return {ill, s, c};
    endfunction

    // {hi, lo} from plain 64-bit arithmetic
    function automatic logic [63:0] mdu_ref(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa, sb, q, r;
        logic [63:0] ua, ub, uq, ur;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        ua = {32'b0, a};
        ub = {32'b0, b};
        if (f[1] && b == 32'b0) return {a, 32'hFFFFFFFF};
        case (f[1:0])
            2'b00: return sa * sb;
            2'b01: return ua * ub;
            2'b10: begin
                q = sa / sb;
                r = sa % sb;
                return {r[31:0], q[31:0]};
            end
            default: begin
                uq = ua / ub;
                ur = ua % ub;
                return {ur[31:0], uq[31:0]};
            end
        endcase
    endfunction

    task automatic issue(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] r;
        next();
        en = 1'b1; aluop = 2'b10; funct = f; srca = a; srcb = b;
        @(negedge clk);
        check("issue_stall", 64'(stall), 0);
        check("issue_idle", 64'(mdu_busy), 0);
        r = mdu_ref(f, a, b);
        {exp_hi, exp_lo} = r;
    endtask

    task automatic run_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
        issue(f, a, b);
        for (int c = 1; c <= W + 1; c++) begin
            next();
            en = 1'b0;
            @(negedge clk);
            check("busy", 64'(mdu_busy), 1);
        end
        next();
        @(negedge clk);
        check("done_busy", 64'(mdu_busy), 0);
        check("hi", 64'(hi), 64'(exp_hi));
        check("lo", 64'(lo), 64'(exp_lo));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [6:0]  d;
        logic [5:0]  f;
        logic [31:0] a, b;
        reset = 1'b1; en = 1'b0; aluop = 2'b00; funct = 6'b0; srca = '0; srcb = '0;
        next();
        next();
        reset = 1'b0;
        @(negedge clk);
        check("rst_busy", 64'(mdu_busy), 0);
        check("rst_stall", 64'(stall), 0);
        check("rst_hi", 64'(hi), 0);
        check("rst_lo", 64'(lo), 0);

        // directed decode points
        aluop = 2'b10; funct = 6'b100111; #1;
        check("dec_nor", 64'({illegal, alucontrol}), 64'({1'b0, 4'b0100}));
        funct = 6'b111111; #1;
        check("dec_bad", 64'({illegal, alucontrol}), 64'({1'b1, 4'b0010}));
        aluop = 2'b00; #1;
        check("dec_add", 64'({illegal, alucontrol}), 64'({1'b0, 4'b0010}));
        aluop = 2'b01; #1;
        check("dec_sub", 64'({illegal, alucontrol}), 64'({1'b0, 4'b0110}));
        aluop = 2'b11; #1;
        check("dec_ori", 64'({illegal, alucontrol}), 64'({1'b0, 4'b0001}));

        // random decode sweep with en low so no HI/LO side effects
        for (int i = 0; i < 300; i++) begin
            next();
            en = 1'b0; aluop = 2'($urandom); funct = 6'($urandom); srca = $urandom; srcb = $urandom;
            @(negedge clk);
            d = dec_ref(aluop, funct);
            check("dec_rand", 64'({illegal, mdu_sel, alucontrol}), 64'(d));
        end
        check("sweep_hi", 64'(hi), 0);

        // directed MDU results
        run_op(6'b011000, 32'hFFFFFFFD, 32'h00000007);
        check("mult_hi", 64'(hi), 64'h0FFFFFFFF);
        check("mult_lo", 64'(lo), 64'h0FFFFFFEB);
        run_op(6'b011001, 32'hFFFFFFFD, 32'h00000007);
        check("multu_hi", 64'(hi), 64'h00000006);
        run_op(6'b011011, 32'd100, 32'd7);
        check("divu", 64'({hi, lo}), 64'h000000020000000E);
        run_op(6'b011010, 32'hFFFFFFF9, 32'd2);
        check("div_neg", 64'({hi, lo}), 64'hFFFFFFFFFFFFFFFD);
        run_op(6'b011010, 32'd5, 32'd0);
        check("div_zero", 64'({hi, lo}), 64'h00000005FFFFFFFF);
        run_op(6'b011010, 32'h80000000, 32'hFFFFFFFF);
        check("div_min", 64'({hi, lo}), 64'h0000000080000000);

        // mflo waiting on a busy multiply
        issue(6'b011000, 32'h00012345, 32'hFFFF0003);
        for (int c = 1; c <= W + 1; c++) begin
            next();
            en = (c >= 5);
            if (c == 5) funct = 6'b010010;
            @(negedge clk);
            if (c >= 5) check("mflo_stall", 64'(stall), 1);
        end
        next();
        @(negedge clk);
        check("mflo_go", 64'(stall), 0);
        check("mflo_sel", 64'(mdu_sel), 2);
        check("mflo_lo", 64'(lo), 64'(exp_lo));

        // second mult and an mthi while busy must both be held off
        issue(6'b011001, 32'hDEAD0001, 32'h0000BEEF);
        for (int c = 1; c <= W + 1; c++) begin
            next();
            en = (c >= 3 && c <= 11);
            funct = (c == 11) ? 6'b010001 : 6'b011000;
            srca = 32'h55AA55AA; srcb = 32'h00000003;
            @(negedge clk);
            if (c >= 3 && c <= 11) check("busy_stall", 64'(stall), 1);
        end
        next();
        en = 1'b0;
        @(negedge clk);
        check("held_hi", 64'(hi), 64'(exp_hi));
        check("held_lo", 64'(lo), 64'(exp_lo));
        next();
        @(negedge clk);
        check("no_reissue", 64'(mdu_busy), 0);

        // mthi / mtlo while idle
        next();
        en = 1'b1; aluop = 2'b10; funct = 6'b010001; srca = 32'h12345678;
        next();
        en = 1'b0;
        @(negedge clk);
        check("mthi", 64'(hi), 64'h12345678);
        a = $urandom;
        next();
        en = 1'b1; funct = 6'b010011; srca = a;
        next();
        en = 1'b0;
        @(negedge clk);
        check("mtlo", 64'(lo), 64'(a));

        // randomized MDU ops
        for (int i = 0; i < 24; i++) begin
            f = {4'b0110, 2'($urandom)};
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 5))
                0: b = 32'd0;
                1: begin a = $urandom_range(0, 1000); b = $urandom_range(1, 20); end
                2: b = -$urandom_range(1, 20);
                default: ;
            endcase
            run_op(f, a, b);
        end

        // reset in the middle of RUN
        issue(6'b011000, 32'h7FFFFFFF, 32'h7FFFFFFF);
        for (int c = 1; c <= 10; c++) begin
            next();
            en = 1'b0;
            reset = (c == 10);
            @(negedge clk);
            check("pre_rst_busy", 64'(mdu_busy), 1);
        end
        next();
        reset = 1'b0; en = 1'b1; aluop = 2'b10; funct = 6'b010000;
        @(negedge clk);
        check("midrst_busy", 64'(mdu_busy), 0);
        check("midrst_hilo", 64'({hi, lo}), 0);
        check("midrst_stall", 64'(stall), 0);
        check("midrst_sel", 64'(mdu_sel), 1);
        next();
        en = 1'b0;
        @(negedge clk);
        check("midrst_idle", 64'(mdu_busy), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
